// File: rtl/am2924_sel_arbiter.sv
// Round-robin arbiter/sequencer that shares one am2924 1-of-8 decoder among eight
// requesters, with a guaranteed disabled cycle between consecutive grants.

// One rotated-priority slot: reports whether requester (start + IDX) mod 8 is asking.
module am2924_sel_arbiter_lane #(
    parameter int IDX = 0
) (
    input  logic [7:0] req,
    input  logic [2:0] start,
    output logic       hit
);
    logic [2:0] src;

    assign src = start + 3'(IDX);
    assign hit = req[src];
endmodule

module am2924_sel_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       inh,
    output logic       c,
    output logic       b,
    output logic       a,
    output logic       g1,
    output logic       g2a_,
    output logic       g2b_,
    output logic [2:0] gid,
    output logic       act
);
    localparam int NUM_REQ = 8;
    // Out-of-range settings are clamped so the 4-bit hold counter can always reach the limit.
    localparam int HOLD_LIM = (HOLD_MAX < 1) ? 1 : ((HOLD_MAX > 15) ? 15 : HOLD_MAX);
    localparam logic [3:0] HOLD_C = 4'(HOLD_LIM);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } state_t;

    state_t              state, state_nx;
    logic [2:0]          last, last_nx;
    logic [3:0]          cnt, cnt_nx;
    logic [2:0]          gid_nx;
    logic                g1_nx, g2a_nx, g2b_nx, act_nx;

    logic [2:0]          start;
    logic [NUM_REQ-1:0]  rreq;
    logic [2:0]          off;
    logic [2:0]          pick;
    logic                any_req;
    logic [NUM_REQ-1:0]  gid_oh;
    logic                others;
    logic                own_req;

    // Requests rotated so that slot 0 is the requester right after the last grantee.
    assign start = last + 3'd1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            am2924_sel_arbiter_lane #(.IDX(gi)) u_lane (
                .req   (req),
                .start (start),
                .hit   (rreq[gi])
            );
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rreq[k]) off = 3'(k);
        end
    end

    assign pick    = start + off;
    assign any_req = |req;
    assign gid_oh  = 8'b1 << gid;
    assign others  = |(req & ~gid_oh);
    assign own_req = req[gid];

    always_comb begin
        state_nx = state;
        last_nx  = last;
        cnt_nx   = cnt;
        gid_nx   = gid;
        g1_nx    = g1;
        g2a_nx   = g2a_;
        g2b_nx   = g2b_;
        act_nx   = act;

        case (state)
            IDLE: begin
                g1_nx  = 1'b0;
                g2a_nx = 1'b1;
                g2b_nx = 1'b1;
                act_nx = 1'b0;
                if (!inh && any_req) begin
                    state_nx = GRANT;
                    gid_nx   = pick;
                    cnt_nx   = 4'd1;
                    g1_nx    = 1'b1;
                    g2a_nx   = 1'b0;
                    g2b_nx   = 1'b0;
                    act_nx   = 1'b1;
                end
            end

            GRANT: begin
                g1_nx  = 1'b1;
                g2a_nx = 1'b0;
                act_nx = 1'b1;
                // A dropped request wins over inhibit, and both win over the hold limit.
                if (!own_req || (!inh && cnt >= HOLD_C && others)) begin
                    state_nx = IDLE;
                    last_nx  = gid;
                    cnt_nx   = '0;
                    g1_nx    = 1'b0;
                    g2a_nx   = 1'b1;
                    g2b_nx   = 1'b1;
                    act_nx   = 1'b0;
                end else if (inh) begin
                    g2b_nx = 1'b1;
                end else if (cnt >= HOLD_C) begin
                    cnt_nx = HOLD_C;
                    g2b_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                    g2b_nx = 1'b0;
                end
            end

            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                g1_nx    = 1'b0;
                g2a_nx   = 1'b1;
                g2b_nx   = 1'b1;
                act_nx   = 1'b0;
            end
        endcase
    end

    // Select lines are registered copies of gid; gid only moves on IDLE->GRANT, while g1 is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 3'd7;
            cnt   <= '0;
            gid   <= '0;
            c     <= 1'b0;
            b     <= 1'b0;
            a     <= 1'b0;
            g1    <= 1'b0;
            g2a_  <= 1'b1;
            g2b_  <= 1'b1;
            act   <= 1'b0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
            gid   <= gid_nx;
            c     <= gid_nx[2];
            b     <= gid_nx[1];
            a     <= gid_nx[0];
            g1    <= g1_nx;
            g2a_  <= g2a_nx;
            g2b_  <= g2b_nx;
            act   <= act_nx;
        end
    end
endmodule

// File: tb/tb_am2924_sel_arbiter.sv
// Scoreboard bench: directed stimulus queues expected grants (grantee, length, gap);
// a negedge monitor checks each grant as the DUT raises and drops act.
module tb_am2924_sel_arbiter;
    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       inh;
    logic       c, b, a, g1, g2a_, g2b_, act;
    logic [2:0] gid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] gid;
        int         len;
        int         gap;   // 0: gap not checked
    } exp_t;

    exp_t exp_q[$];

    am2924_sel_arbiter #(.HOLD_MAX(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .inh  (inh),
        .c    (c),
        .b    (b),
        .a    (a),
        .g1   (g1),
        .g2a_ (g2a_),
        .g2b_ (g2b_),
        .gid  (gid),
        .act  (act)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] g, input int len, input int gap);
        exp_t e;
        e.gid = g;
        e.len = len;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic chk_disabled(input string nm);
        chk({nm, "_act"}, act, 0);
        chk({nm, "_g1"}, g1, 0);
        chk({nm, "_g2a"}, g2a_, 1);
        chk({nm, "_g2b"}, g2b_, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // Monitor: grant start on act rising, grant end on act falling.
    logic act_q = 1'b0;
    int   len_cnt = 0;
    int   idle_cnt = 0;
    exp_t cur;
    logic have_cur = 1'b0;

    always @(negedge clk) begin
        if (act === 1'b1 && act_q === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                have_cur = 1'b0;
                $display("FAIL unexpected_grant: got gid %0d want none", gid);
            end else begin
                cur = exp_q[0];
                have_cur = 1'b1;
                chk("grant_gid", gid, cur.gid);
                chk("grant_cba", {c, b, a}, cur.gid);
                chk("grant_enables", {g1, g2a_, g2b_}, 3'b100);
                if (cur.gap != 0) chk("grant_gap", idle_cnt, cur.gap);
            end
            len_cnt = 1;
        end else if (act === 1'b1) begin
            len_cnt++;
        end else if (act_q === 1'b1) begin
            chk("release_enables", {g1, g2a_, g2b_}, 3'b011);
            if (have_cur) begin
                chk("grant_len", len_cnt, cur.len);
                void'(exp_q.pop_front());
                have_cur = 1'b0;
            end
            idle_cnt = 1;
        end else begin
            idle_cnt++;
        end
        act_q = act;
    end

    initial begin
        rst = 1'b1;
        req = 8'h00;
        inh = 1'b0;

        // Reset with no clock running
        #3;
        chk("rst_cba", {c, b, a}, 3'b000);
        chk("rst_gid", gid, 0);
        chk_disabled("rst");
        clk_run = 1'b1;
        do_reset();

        // Single requester 5, three request cycles
        push(3'd5, 3, 0);
        req = 8'h20;
        tick();
        chk("single_gid", gid, 5);
        chk("single_cba", {c, b, a}, 3'b101);
        tick();
        tick();
        req = 8'h00;
        tick();
        chk_disabled("single_rel");
        repeat (3) tick();

        // Full contention from a fresh reset: 0..7 then 0, four cycles each
        do_reset();
        push(3'd0, 4, 0);
        for (int i = 1; i < 8; i++) push(3'(i), 4, 1);
        push(3'd0, 2, 1);
        req = 8'hFF;
        repeat (42) tick();
        req = 8'h00;
        repeat (4) tick();

        // Wrap-around: 6 released, then 7, 0, 1
        push(3'd6, 2, 0);
        push(3'd7, 4, 1);
        push(3'd0, 4, 1);
        push(3'd1, 2, 1);
        req = 8'h40;
        repeat (2) tick();
        req = 8'h83;
        repeat (13) tick();
        req = 8'h00;
        repeat (4) tick();

        // Inhibit during grant to 3: two frozen cycles stretch the preempted grant to 6
        push(3'd3, 6, 0);
        push(3'd4, 1, 1);
        req = 8'h18;
        tick();
        chk("inh_pre_g2b", g2b_, 0);
        inh = 1'b1;
        tick();
        chk("inh_g2b_1", g2b_, 1);
        chk("inh_act_1", act, 1);
        chk("inh_gid_1", gid, 3);
        chk("inh_g1_1", {g1, g2a_}, 2'b10);
        tick();
        chk("inh_g2b_2", g2b_, 1);
        chk("inh_gid_2", gid, 3);
        inh = 1'b0;
        tick();
        chk("inh_resume_g2b", g2b_, 0);
        chk("inh_resume_act", act, 1);
        repeat (4) tick();
        req = 8'h00;
        repeat (2) tick();

        // Inhibit in IDLE blocks the grant until it drops
        push(3'd0, 2, 0);
        inh = 1'b1;
        req = 8'h01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_disabled("inh_idle");
        end
        inh = 1'b0;
        tick();
        chk("inh_idle_grant_act", act, 1);
        chk("inh_idle_grant_gid", gid, 0);
        tick();
        req = 8'h00;
        repeat (4) tick();

        // Reset mid-grant to 6; round robin restarts at 0
        push(3'd6, 1, 0);
        req = 8'h40;
        tick();
        chk("midrst_gid", gid, 6);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_gid0", gid, 0);
        chk("midrst_cba", {c, b, a}, 3'b000);
        chk_disabled("midrst");
        push(3'd0, 4, 0);
        push(3'd6, 1, 1);
        tick();
        req = 8'h41;
        #3;
        rst = 1'b0;
        repeat (6) tick();
        req = 8'h00;

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk("queue_drained", exp_q.size(), 0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
